blink_scheduler: RTL and testbench
==================================

Name: blink_scheduler

Overview:
- Sequences NUM_CH LED blink channels from one shared random-interval source.
- Each channel counts its own interval and emits a one-cycle LED pulse when the count expires.
- Channels in random mode request a fresh interval after each pulse; a round-robin arbiter grants the shared source to one requester per cycle.
- Sits between the LFSR random-number source and the board LED pins; the host reconfigures channels through a valid/ready port.

Parameters:
- NUM_CH, 3, number of LED channels (2..8).
- IW, 4, interval width in bits.
- RW, 5, width of the random source data bus (RW >= IW).
- DEF_INTERVAL, {4'd15,4'd4,4'd9}, per-channel reset interval, packed NUM_CH*IW; channel 0 in the LSBs.
- DEF_MODE, 3'b100, per-channel reset mode; 1 = random, 0 = fixed.

Ports:
- clk_edge  in  1  clock; all state updates on posedge.
- rstbtn  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when both cfg_valid and cfg_ready are 1.
- cfg_chan  in  3  target channel.
- cfg_mode  in  1  1 = random, 0 = fixed.
- cfg_interval  in  IW  new interval; 0 disables the channel.
- rnd_valid  in  1  random source has data.
- rnd_data  in  RW  random value; only bits [IW-1:0] are used.
- rnd_ready  out  1  random value consumed this cycle.
- led  out  NUM_CH  per-channel blink pulse.

Behaviour:
- Reset (async, rstbtn=1): led=0, rnd_ready=0, cfg_ready=0, all counts=0, pending=0, rr pointer=0.
- Reset also loads interval and mode from DEF_INTERVAL and DEF_MODE, and puts the config FSM in IDLE.
- Release is synchronous to clk_edge. cfg_ready goes 1 on the first posedge after release.
- Channel counter:
  - IW-bit count runs 0..interval.
  - When count==interval: led[i]=1 for exactly one cycle and count returns to 0.
  - Period is interval+1 cycles.
  - interval==0: channel disabled, led[i]=0, count held at 0, no requests raised.
  - led is registered: it goes high on the posedge where count==interval is sampled.
- Random request:
  - In random mode, a pulse sets pending[i] on the same edge.
  - The channel keeps counting with its old interval while pending.
  - A pulse while already pending leaves pending set (no queuing).
- Arbiter:
  - Combinational grant = lowest-index pending channel at or after rr pointer, wrapping.
  - rnd_ready = rnd_valid & (any pending) & no config collision on the granted channel.
  - When rnd_ready=1, a nonzero rnd_data[IW-1:0] is written to the granted channel's interval and clears its pending bit; count is not touched.
  - A zero value is consumed and discarded; pending stays set and the channel retries next cycle.
  - The rr pointer moves to grant+1 (mod NUM_CH) on every consumption.
- Config FSM, IDLE -> APPLY -> IDLE:
  - IDLE: cfg_ready=1. A handshake latches chan, mode and interval, then moves to APPLY.
  - APPLY: cfg_ready=0. On the next edge it writes interval and mode, clears count, led and pending for that channel, then returns to IDLE.
  - Maximum throughput is one config per 2 cycles.
  - cfg_chan >= NUM_CH: the handshake completes and the write is ignored.
- Simultaneous events:
  - Config APPLY and an arbiter grant on the same channel in the same cycle: config wins, the grant is masked, rnd_ready=0.
  - Another pending channel is not granted that cycle.
  - Random-to-fixed reconfigure drops any pending request.
- Reset mid-operation abandons APPLY and all pending requests immediately.

Optional Feature:
- Macro: BLINK_SCHED_STATUS_EN.
- Defined:
  - Adds output pending_o [NUM_CH-1:0], mirroring the pending bits.
  - Adds output starve_o [1:0], a saturating count of consecutive zero values discarded.
  - starve_o clears on any nonzero consumption and on reset.
- Undefined: neither port exists and channel behaviour is identical.

Decomposition:
- Shared package blink_pkg holds:
  - constants IW_DEF=4, RW_DEF=5, MAX_CH=8;
  - enum cfg_state_t {CFG_IDLE, CFG_APPLY};
  - typedef mode_t (FIXED=0, RANDOM=1).
- One natural sub-module: blink_rr_arbiter. Inputs: NUM_CH request vector, pointer. Output: one-hot grant and grant index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset defaults, rnd_valid=0, 60 cycles:
  - led[0] pulses every 10 cycles and led[1] every 5 cycles.
  - led[2] pulses at count 15, raises pending, then keeps a 16-cycle period.
- Channel 2 pending, rnd_data=5'b10011 with rnd_valid for 1 cycle:
  - rnd_ready=1 for that cycle and interval becomes 3.
  - led[2] then pulses every 4 cycles.
- rnd_data=0 while channel 2 is pending:
  - rnd_ready=1 and the value is discarded; pending stays set.
  - Next cycle rnd_data=7 is accepted and the interval becomes 7.
- Set all three channels random, force simultaneous pulses, hold rnd_valid=1 with values 1, 2, 3:
  - Grants go ch0, ch1, ch2 over 3 consecutive cycles.
  - The pointer ends at 0.
- Config ch1 to fixed interval 0 in the same cycle ch1 would be granted:
  - rnd_ready=0 that cycle; led[1] stays 0 thereafter.
  - cfg_ready=0 for exactly 1 cycle.
- Assert rstbtn mid-APPLY, between edges:
  - All led and rnd_ready outputs drop immediately.
  - After release, defaults are restored and cfg_ready=1 on the first posedge.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink scheduler and its round-robin arbiter.
package blink_pkg;

    localparam int IW_DEF = 4;
    localparam int RW_DEF = 5;
    localparam int MAX_CH = 8;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    typedef enum logic {
        FIXED  = 1'b0,
        RANDOM = 1'b1
    } mode_t;

endpackage

// File: rtl/blink_rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest-index request at or after ptr, wrapping.
module blink_rr_arbiter
    import blink_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PW     = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PW-1:0]     grant_idx
);

    logic found;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return PW'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[wrap_add(ptr, k)]) begin
                found     = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/blink_scheduler.sv
// NUM_CH LED blink channels sharing one random-interval source; host reconfigures via valid/ready.
// Optional status outputs (pending_o, starve_o) are enabled with BLINK_SCHED_STATUS_EN.
module blink_scheduler
    import blink_pkg::*;
#(
    parameter int                   NUM_CH       = 3,
    parameter int                   IW           = IW_DEF,
    parameter int                   RW           = RW_DEF,
    parameter logic [NUM_CH*IW-1:0] DEF_INTERVAL = {4'd15, 4'd4, 4'd9},
    parameter logic [NUM_CH-1:0]    DEF_MODE     = 3'b100
) (
    input  logic              clk_edge,
    input  logic              rstbtn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_chan,
    input  logic              cfg_mode,
    input  logic [IW-1:0]     cfg_interval,
    input  logic              rnd_valid,
    input  logic [RW-1:0]     rnd_data,
    output logic              rnd_ready,
    output logic [NUM_CH-1:0] led
`ifdef BLINK_SCHED_STATUS_EN
    ,
    output logic [NUM_CH-1:0] pending_o,
    output logic [1:0]        starve_o
`endif
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(MAX_CH);

    cfg_state_t        state, state_nxt;
    logic              run;
    logic [CW-1:0]     cfg_chan_q;
    mode_t             cfg_mode_q;
    logic [IW-1:0]     cfg_interval_q;

    logic [IW-1:0]     count    [NUM_CH];
    logic [IW-1:0]     interval [NUM_CH];
    logic [NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0] pending;

    logic [NUM_CH-1:0] grant;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     rr_ptr;
    logic              applying;
    logic              collision;
    logic              take;
    logic [IW-1:0]     rnd_val;

    generate
        if (RW > IW) begin : g_unused_rnd
            logic unused_rnd_hi;
            assign unused_rnd_hi = ^rnd_data[RW-1:IW];
        end
    endgenerate

    blink_rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A config write to the granted channel this cycle wins; the grant is masked entirely.
    assign applying  = (state == CFG_APPLY);
    assign collision = applying && (int'(cfg_chan_q) == int'(grant_idx));
    assign rnd_ready = rnd_valid && (|pending) && !collision;
    assign rnd_val   = rnd_data[IW-1:0];
    assign take      = rnd_ready && (rnd_val != '0);

    // cfg_ready is held low until the first edge after reset release via run.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        case (state)
            CFG_IDLE: begin
                cfg_ready = run;
                if (cfg_valid && run) state_nxt = CFG_APPLY;
            end
            CFG_APPLY: state_nxt = CFG_IDLE;
            default:   state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk_edge or posedge rstbtn) begin
        if (rstbtn) begin
            state          <= CFG_IDLE;
            run            <= 1'b0;
            cfg_chan_q     <= '0;
            cfg_mode_q     <= FIXED;
            cfg_interval_q <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (cfg_valid && cfg_ready) begin
                cfg_chan_q     <= cfg_chan;
                cfg_mode_q     <= mode_t'(cfg_mode);
                cfg_interval_q <= cfg_interval;
            end
        end
    end

    // A random value served on the same edge as a fresh pulse satisfies that pulse too.
    always_ff @(posedge clk_edge or posedge rstbtn) begin
        if (rstbtn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]    <= '0;
                interval[i] <= DEF_INTERVAL[i*IW +: IW];
            end
            mode_r  <= DEF_MODE;
            pending <= '0;
            led     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (applying && (int'(cfg_chan_q) == i)) begin
                    interval[i] <= cfg_interval_q;
                    mode_r[i]   <= (cfg_mode_q == RANDOM);
                    count[i]    <= '0;
                    led[i]      <= 1'b0;
                    pending[i]  <= 1'b0;
                end else begin
                    led[i] <= 1'b0;
                    if (interval[i] == '0) begin
                        count[i] <= '0;
                    end else if (count[i] == interval[i]) begin
                        led[i]   <= 1'b1;
                        count[i] <= '0;
                        if (mode_r[i]) pending[i] <= 1'b1;
                    end else begin
                        count[i] <= count[i] + 1'b1;
                    end
                    if (take && grant[i]) begin
                        interval[i] <= rnd_val;
                        pending[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_edge or posedge rstbtn) begin
        if (rstbtn) begin
            rr_ptr <= '0;
        end else if (rnd_ready) begin
            rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef BLINK_SCHED_STATUS_EN
    logic [1:0] starve;

    always_ff @(posedge clk_edge or posedge rstbtn) begin
        if (rstbtn) begin
            starve <= '0;
        end else if (take) begin
            starve <= '0;
        end else if (rnd_ready && (starve != 2'd3)) begin
            starve <= starve + 2'd1;
        end
    end

    assign pending_o = pending;
    assign starve_o  = starve;
`endif

endmodule

// File: tb/tb_blink_scheduler.sv
// Scoreboard bench for blink_scheduler: a cycle-level reference model pushes expected outputs, a monitor compares.
module tb_blink_scheduler;

    localparam int NUM_CH = 3;
    localparam int IW     = 4;
    localparam int RW     = 5;
    localparam int OW     = NUM_CH + 2;

    logic              clk_edge = 1'b0;
    logic              rstbtn   = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_chan = '0;
    logic              cfg_mode = 1'b0;
    logic [IW-1:0]     cfg_interval = '0;
    logic              rnd_valid = 1'b0;
    logic [RW-1:0]     rnd_data = '0;
    logic              rnd_ready;
    logic [NUM_CH-1:0] led;

    int check_cnt = 0;
    int pass_cnt  = 0;
    bit mon_en    = 1'b1;

    logic [OW-1:0] exp_q[$];

    blink_scheduler #(
        .NUM_CH       (NUM_CH),
        .IW           (IW),
        .RW           (RW),
        .DEF_INTERVAL ({4'd15, 4'd4, 4'd9}),
        .DEF_MODE     (3'b100)
    ) dut (
        .clk_edge     (clk_edge),
        .rstbtn       (rstbtn),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_mode     (cfg_mode),
        .cfg_interval (cfg_interval),
        .rnd_valid    (rnd_valid),
        .rnd_data     (rnd_data),
        .rnd_ready    (rnd_ready),
        .led          (led)
    );

    // clock / reset
    always #5 clk_edge = ~clk_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference model: spec-level channel/arbiter/config behaviour in plain integers
    int m_cnt [NUM_CH];
    int m_ivl [NUM_CH];
    bit m_rand[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_led [NUM_CH];
    int m_ptr;
    bit m_run, m_busy, m_amode;
    int m_ach, m_aivl;

    task automatic model_reset();
        int def_ivl[NUM_CH] = '{9, 4, 15};
        bit def_rnd[NUM_CH] = '{0, 0, 1};
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c]  = 0;
            m_ivl[c]  = def_ivl[c];
            m_rand[c] = def_rnd[c];
            m_pend[c] = 0;
            m_led[c]  = 0;
        end
        m_ptr = 0; m_run = 0; m_busy = 0; m_amode = 0; m_ach = 0; m_aivl = 0;
    endtask

    task automatic model_step();
        int g = -1;
        bit rr, crdy;
        int val;
        logic [NUM_CH-1:0] lv;
        for (int k = 0; k < NUM_CH; k++) begin
            int c = (m_ptr + k) % NUM_CH;
            if (g < 0 && m_pend[c]) g = c;
        end
        rr   = rnd_valid && (g >= 0) && !(m_busy && m_ach == g);
        crdy = m_run && !m_busy;
        for (int c = 0; c < NUM_CH; c++) lv[c] = m_led[c];
        exp_q.push_back({rr, crdy, lv});

        val = int'(rnd_data) % 16;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_busy && m_ach == c) begin
                m_ivl[c] = m_aivl; m_rand[c] = m_amode;
                m_cnt[c] = 0; m_led[c] = 0; m_pend[c] = 0;
            end else begin
                m_led[c] = 0;
                if (m_ivl[c] == 0) m_cnt[c] = 0;
                else if (m_cnt[c] == m_ivl[c]) begin
                    m_led[c] = 1; m_cnt[c] = 0;
                    if (m_rand[c]) m_pend[c] = 1;
                end else m_cnt[c] = (m_cnt[c] + 1) % 16;
                if (rr && g == c && val != 0) begin
                    m_ivl[c] = val; m_pend[c] = 0;
                end
            end
        end
        if (rr) m_ptr = (g + 1) % NUM_CH;
        if (m_busy) m_busy = 0;
        else if (cfg_valid && crdy) begin
            m_busy = 1; m_ach = int'(cfg_chan); m_amode = cfg_mode; m_aivl = int'(cfg_interval);
        end
        m_run = 1;
    endtask

    always @(negedge clk_edge) begin
        if (rstbtn) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_step();
        end
    end

    // monitor: one observation of {rnd_ready, cfg_ready, led} per cycle
    always @(negedge clk_edge) begin
        logic [OW-1:0] e;
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL sb_empty: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("outputs", 32'({rnd_ready, cfg_ready, led}), 32'(e));
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_edge);
            #1;
        end
    endtask

    task automatic do_cfg(input int ch, input bit md, input int iv);
        int w = 0;
        while (!cfg_ready && w < 10) begin
            tick(1);
            w++;
        end
        if (w == 10) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        cfg_valid    = 1'b1;
        cfg_chan     = 3'(ch);
        cfg_mode     = md;
        cfg_interval = IW'(iv);
        tick(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        rstbtn = 1'b0;

        // defaults with no random data
        tick(60);

        // channel 2 pending: serve value 0b10011 -> interval 3
        rnd_valid = 1'b1;
        rnd_data  = 5'b10011;
        #1 check("rnd_ready_first", 32'(rnd_ready), 32'd1);
        tick(1);
        rnd_valid = 1'b0;
        tick(20);

        // zero is discarded, then 7 accepted
        rnd_valid = 1'b1;
        rnd_data  = '0;
        #1 check("rnd_ready_zero", 32'(rnd_ready), 32'd1);
        tick(1);
        rnd_data = 5'd7;
        #1 check("rnd_ready_retry", 32'(rnd_ready), 32'd1);
        tick(1);
        rnd_valid = 1'b0;
        tick(20);

        // all channels random, all pending, served round-robin
        do_cfg(0, 1'b1, 5);
        do_cfg(1, 1'b1, 5);
        do_cfg(2, 1'b1, 5);
        tick(20);
        rnd_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            rnd_data = RW'(v);
            #1 check("rnd_ready_rr", 32'(rnd_ready), 32'd1);
            tick(1);
        end
        rnd_valid = 1'b0;
        tick(10);

        // config collision on channel 1
        do_cfg(0, 1'b0, 6);
        do_cfg(2, 1'b0, 9);
        do_cfg(1, 1'b1, 1);
        tick(6);
        do_cfg(1, 1'b0, 0);
        rnd_valid = 1'b1;
        rnd_data  = 5'd5;
        #1 check("rnd_ready_collision", 32'(rnd_ready), 32'd0);
        check("cfg_ready_apply", 32'(cfg_ready), 32'd0);
        tick(1);
        rnd_valid = 1'b0;
        #1 check("cfg_ready_back", 32'(cfg_ready), 32'd1);
        tick(30);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cfg_valid    = ($urandom_range(0, 7) == 0);
            cfg_chan     = 3'($urandom_range(0, 7));
            cfg_mode     = 1'($urandom_range(0, 1));
            cfg_interval = IW'($urandom_range(0, 15));
            rnd_valid    = 1'($urandom_range(0, 1));
            rnd_data     = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom_range(0, 31));
            tick(1);
        end
        cfg_valid = 1'b0;
        rnd_valid = 1'b0;
        tick(5);

        // asynchronous reset in the middle of APPLY
        do_cfg(1, 1'b1, 3);
        rnd_valid = 1'b1;
        rnd_data  = 5'd1;
        #2 rstbtn = 1'b1;
        #1 check("rst_led", 32'(led), 32'd0);
        check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        tick(2);
        rstbtn    = 1'b0;
        rnd_valid = 1'b0;
        #1 check("cfg_ready_pre_edge", 32'(cfg_ready), 32'd0);
        tick(1);
        check("cfg_ready_first_edge", 32'(cfg_ready), 32'd1);
        tick(60);

        tick(2);
        mon_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
